mul_div_unit: RTL
=================

// Module: mul_div_unit
// PURPOSE
//  Iterative 16-bit multiply/divide unit, downstream of the register file. Consumes the A/B
//  read operands; shift-add multiply or restoring divide over WIDTH cycles. Writes the 2-word
//  result back through the register file write port (WriteEnable/SelectInput/In) in two
//  consecutive cycles. Lets the single-cycle ALU path omit MUL/DIV hardware.
// PARAMETERS
//  WIDTH    16  operand/register data width
//  SEL_W    4   register select width (16 registers)
// PORTS
//  Clock        in   1        system clock, rising edge
//  Reset        in   1        asynchronous, active-low reset
//  Start        in   1        request; sampled only in IDLE
//  Op           in   2        00 MULU, 01 MULS (two's complement), 10 DIVU, 11 reserved
//  OpA          in   WIDTH    operand A (register file A output)
//  OpB          in   WIDTH    operand B (register file B output)
//  Dest         in   SEL_W    destination register for low word / quotient
//  Busy         out  1        high in every state except IDLE
//  Done         out  1        one-cycle pulse, coincident with second write-back
//  DivByZero    out  1        held with Done when a DIVU had OpB==0
//  WriteEnable  out  1        register file write enable
//  SelectInput  out  SEL_W    register file write select
//  WbData       out  WIDTH    register file write data (drives RegFile In)
// BEHAVIOUR
//  Clock/reset: one clock. Reset low asynchronously forces IDLE. All outputs 0 and all
//   internal registers cleared while Reset is low; effective on the first edge after release.
//  States: IDLE -> CALC -> WB_LO -> WB_HI -> IDLE.
//  IDLE: Start=1 and Op!=11 at edge 0 latch OpA, OpB, Op and Dest. Next state CALC, counter=WIDTH-1.
//   Start with Op=11 is ignored (stay IDLE, no write, no Done).
//  CALC: one iteration per cycle. Leave to WB_LO on the edge where counter==0, so CALC spans
//   cycles 1..WIDTH.
//   MULU: 2*WIDTH-bit product, shift-add.
//   MULS: multiply magnitudes, negate the 2*WIDTH product if operand signs differ.
//    -32768*-32768 = 0x40000000 (no overflow in 32 bits).
//   DIVU: restoring division; quotient and remainder, both unsigned.
//   DIVU with latched OpB==0: skip CALC entirely (IDLE -> WB_LO). Quotient=0xFFFF,
//    remainder=OpA, DivByZero=1.
//  WB_LO (cycle WIDTH+1, or 1 for div-by-zero):
//   WriteEnable=1, SelectInput=Dest, WbData = product[15:0] or quotient.
//  WB_HI (next cycle):
//   WriteEnable=1, SelectInput=(Dest+1) mod 16 (Dest=15 wraps to 0),
//    WbData = product[31:16] or remainder.
//   Done=1; DivByZero valid this cycle only.
//  Output timing:
//   All outputs are registered, and WriteEnable=0 outside WB_LO/WB_HI.
//   SelectInput and WbData hold their last value when not writing; they read 0 after reset.
//  Latency: Start edge -> WB_LO at cycle 17, WB_HI/Done at cycle 18, Busy low at cycle 19
//   (div-by-zero: cycles 1, 2, 3). Back-to-back: a new Start is accepted at cycle 19.
//  Start while Busy: ignored, with no effect on the in-flight operation.
//  OpA/OpB may change freely after the Start edge.
//  Reset mid-operation (any state): the operation is abandoned, no further writes,
//   Done is not pulsed.
//  Handshake: caller must hold the destination read/write ports free during WB_LO/WB_HI.
//   Busy is the stall signal.
// TESTING
//  MULU 300*200, Dest=2 -> R2=0xEA60 at cycle 17, R3=0x0000 at cycle 18, Done pulse at cycle 18.
//  MULU 0xFFFF*0xFFFF -> lo=0x0001, hi=0xFFFE.
//   MULS 0xFFFD*7 -> lo=0xFFEB, hi=0xFFFF.
//   MULS 0x8000*0x8000 -> lo=0x0000, hi=0x4000.
//  DIVU 100/7, Dest=15 -> R15=14, R0=2 (wrap); DivByZero=0.
//   DIVU 0x1234/0 -> writes at cycles 1 and 2: 0xFFFF then 0x1234; DivByZero=1 with Done.
//  Start pulsed at cycles 5 and 10 during CALC with different operands
//   -> ignored, original result written.
//   Op=11 Start -> Busy stays 0, no WriteEnable.
//  Reset low at cycle 8 of a MULU -> outputs 0 at once, no write-back, no Done.
//   After release, a new MULU 3*4 -> 12 at cycle 17.

Source files
------------

// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit: shift-add MULU/MULS and restoring DIVU over WIDTH cycles.
// The two-word result goes back through the register file write port in two consecutive cycles.
module mul_div_unit #(
    parameter int WIDTH = 16,
    parameter int SEL_W = 4
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Start,
    input  logic [1:0]       Op,
    input  logic [WIDTH-1:0] OpA,
    input  logic [WIDTH-1:0] OpB,
    input  logic [SEL_W-1:0] Dest,
    output logic             Busy,
    output logic             Done,
    output logic             DivByZero,
    output logic             WriteEnable,
    output logic [SEL_W-1:0] SelectInput,
    output logic [WIDTH-1:0] WbData
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [1:0] OP_MULU = 2'b00;
    localparam logic [1:0] OP_MULS = 2'b01;
    localparam logic [1:0] OP_DIVU = 2'b10;
    localparam logic [1:0] OP_RSVD = 2'b11;
    localparam logic [WIDTH-1:0]   ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [2*WIDTH-1:0] ONE_2W = {{(2*WIDTH-1){1'b0}}, 1'b1};
    localparam logic [SEL_W-1:0]   ONE_S  = {{(SEL_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, CALC, WB_LO, WB_HI} state_t;

    state_t             state_r;
    logic [1:0]         op_r;
    logic [WIDTH-1:0]   m_r;
    logic [2*WIDTH-1:0] acc_r;
    logic               neg_r;
    logic [SEL_W-1:0]   dest_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [WIDTH-1:0]   hi_r;
    logic               dz_r;
    logic               busy_r;
    logic               done_r;
    logic               dz_out_r;
    logic               we_r;
    logic [SEL_W-1:0]   sel_r;
    logic [WIDTH-1:0]   data_r;

    logic [WIDTH:0]     sum_s;
    logic [WIDTH:0]     shl_s;
    logic [WIDTH-1:0]   diff_s;
    logic               ge_s;
    logic [2*WIDTH-1:0] next_acc_s;
    logic [2*WIDTH-1:0] final_s;

    // Magnitude of a value, treated as two's complement only when sgn is set
    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic sgn);
        logic [WIDTH-1:0] r;
        if (sgn && v[WIDTH-1]) begin
            r = ~v + ONE_W;
        end else begin
            r = v;
        end
        return r;
    endfunction

    // One shift-add or restoring-divide iteration; acc holds {upper, lower} words
    always_comb begin
        sum_s  = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + {1'b0, m_r};
        shl_s  = {acc_r[2*WIDTH-1:WIDTH], acc_r[WIDTH-1]};
        ge_s   = (shl_s >= {1'b0, m_r});
        diff_s = shl_s[WIDTH-1:0] - m_r;
        next_acc_s = acc_r;
        if (op_r == OP_DIVU) begin
            next_acc_s = {(ge_s ? diff_s : shl_s[WIDTH-1:0]), acc_r[WIDTH-2:0], ge_s};
        end else if (acc_r[0]) begin
            next_acc_s = {sum_s, acc_r[WIDTH-1:1]};
        end else begin
            next_acc_s = {1'b0, acc_r[2*WIDTH-1:1]};
        end
        if (neg_r) begin
            final_s = ~next_acc_s + ONE_2W;
        end else begin
            final_s = next_acc_s;
        end
    end

    // Sequencer FSM with registered write-port outputs
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_r  <= IDLE;
            op_r     <= 2'b00;
            m_r      <= '0;
            acc_r    <= '0;
            neg_r    <= 1'b0;
            dest_r   <= '0;
            cnt_r    <= '0;
            hi_r     <= '0;
            dz_r     <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            dz_out_r <= 1'b0;
            we_r     <= 1'b0;
            sel_r    <= '0;
            data_r   <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    done_r   <= 1'b0;
                    dz_out_r <= 1'b0;
                    we_r     <= 1'b0;
                    if (Start && (Op != OP_RSVD)) begin
                        op_r   <= Op;
                        dest_r <= Dest;
                        cnt_r  <= CNT_W'(WIDTH - 1);
                        busy_r <= 1'b1;
                        if (Op == OP_DIVU) begin
                            m_r   <= OpB;
                            acc_r <= {{WIDTH{1'b0}}, OpA};
                            neg_r <= 1'b0;
                            if (OpB == '0) begin
                                // Divide by zero bypasses CALC and writes the fixed result
                                state_r <= WB_LO;
                                dz_r    <= 1'b1;
                                hi_r    <= OpA;
                                we_r    <= 1'b1;
                                sel_r   <= Dest;
                                data_r  <= {WIDTH{1'b1}};
                            end else begin
                                state_r <= CALC;
                                dz_r    <= 1'b0;
                            end
                        end else begin
                            state_r <= CALC;
                            dz_r    <= 1'b0;
                            m_r     <= mag(OpA, Op == OP_MULS);
                            acc_r   <= {{WIDTH{1'b0}}, mag(OpB, Op == OP_MULS)};
                            neg_r   <= (Op == OP_MULS) && (OpA[WIDTH-1] ^ OpB[WIDTH-1]);
                        end
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                CALC: begin
                    if (cnt_r == '0) begin
                        state_r <= WB_LO;
                        we_r    <= 1'b1;
                        sel_r   <= dest_r;
                        data_r  <= final_s[WIDTH-1:0];
                        hi_r    <= final_s[2*WIDTH-1:WIDTH];
                    end else begin
                        acc_r <= next_acc_s;
                        cnt_r <= cnt_r - 1'b1;
                    end
                end
                WB_LO: begin
                    state_r  <= WB_HI;
                    we_r     <= 1'b1;
                    sel_r    <= dest_r + ONE_S;
                    data_r   <= hi_r;
                    done_r   <= 1'b1;
                    dz_out_r <= dz_r;
                end
                WB_HI: begin
                    state_r  <= IDLE;
                    we_r     <= 1'b0;
                    done_r   <= 1'b0;
                    dz_out_r <= 1'b0;
                    busy_r   <= 1'b0;
                end
                default: begin
                    state_r  <= IDLE;
                    we_r     <= 1'b0;
                    done_r   <= 1'b0;
                    dz_out_r <= 1'b0;
                    busy_r   <= 1'b0;
                end
            endcase
        end
    end

    assign Busy        = busy_r;
    assign Done        = done_r;
    assign DivByZero   = dz_out_r;
    assign WriteEnable = we_r;
    assign SelectInput = sel_r;
    assign WbData      = data_r;

endmodule
